exec_unit_p: RTL and testbench

- Parametrised next-generation ALU/MEM/IO execution unit for the core's second issue slot.
- Accepts one decoded instruction per cycle (ope, ds_val, dt_val, dd, imm).
- Returns results on three independent writeback ports (alu, mem, io).
- Over the previous unit it adds: a free-running memory pipeline with configurable RAM latency, buffered input and output byte FIFOs (non-blocking OUT, prefetched IN), configurable data-address width, and asynchronous reset.

---
 rtl/exec_unit_p.sv | 273 +++++++++++++++++++++++++++
 tb/tb_exec_unit_p.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_p.sv
// exec_unit_p: second-issue-slot ALU/MEM/IO execution unit with pipelined RAM and byte FIFOs.
// Define EXEC_UNIT_P_MUL_EN to add MUL (110100) on the ALU writeback port.
module exec_unit_p #(
   parameter int unsigned RAM_LAT   = 2,
   parameter int unsigned DADDR_W   = 17,
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [5:0]         ope,
   input  logic [31:0]        ds_val,
   input  logic [31:0]        dt_val,
   input  logic [5:0]         dd,
   input  logic [15:0]        imm,
   output logic [6:0]         is_busy,
   output logic [5:0]         alu_addr,
   output logic [31:0]        alu_dd_val,
   output logic [5:0]         mem_addr,
   output logic [31:0]        mem_dd_val,
   output logic [5:0]         io_addr,
   output logic [31:0]        io_dd_val,
   output logic [DADDR_W-1:0] d_addr,
   output logic [31:0]        d_wdata,
   input  logic [31:0]        d_rdata,
   output logic               d_en,
   output logic               d_we,
   input  logic [7:0]         io_in_data,
   input  logic               io_in_vld,
   output logic               io_in_rdy,
   output logic [7:0]         io_out_data,
   output logic               io_out_vld,
   input  logic               io_out_rdy
);

   localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
   localparam int unsigned IN_CW  = $clog2(IN_DEPTH + 1);
   localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
   localparam int unsigned OUT_CW = $clog2(OUT_DEPTH + 1);

   localparam logic [5:0] OpLui  = 6'b110000;
   localparam logic [5:0] OpAdd  = 6'b001100;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpSub  = 6'b010100;
   localparam logic [5:0] OpSll  = 6'b011100;
   localparam logic [5:0] OpSlli = 6'b011000;
   localparam logic [5:0] OpSrl  = 6'b100100;
   localparam logic [5:0] OpSrli = 6'b100000;
   localparam logic [5:0] OpSra  = 6'b101100;
   localparam logic [5:0] OpSrai = 6'b101000;
`ifdef EXEC_UNIT_P_MUL_EN
   localparam logic [5:0] OpMul  = 6'b110100;
`endif

   typedef enum logic [0:0] {StIdle, StDrain} io_state_e;

   // Decode
   logic        is_io, is_mem, is_load, is_fence, is_in, is_out;
   logic [31:0] sext_imm, op2;
   logic [4:0]  shamt;

   assign is_io    = (ope[2:0] == 3'b011);
   assign is_mem   = (ope[2:0] == 3'b111);
   assign is_load  = is_mem & ope[3];
   assign is_fence = is_io & ope[5];
   assign is_in    = is_io & ~ope[5] & ope[3];
   assign is_out   = is_io & ~ope[5] & ~ope[3];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign op2      = ope[2] ? dt_val : sext_imm;
   assign shamt    = op2[4:0];

   // ALU
   logic        alu_hit;
   logic [31:0] alu_res;
   logic [5:0]  alu_addr_q;
   logic [31:0] alu_val_q;

   always_comb begin
      alu_hit = 1'b1;
      alu_res = '0;
      case (ope)
         OpLui:         alu_res = {imm, ds_val[15:0]};
         OpAdd, OpAddi: alu_res = ds_val + op2;
         OpSub:         alu_res = ds_val - op2;
         OpSll, OpSlli: alu_res = ds_val << shamt;
         OpSrl, OpSrli: alu_res = ds_val >> shamt;
         OpSra, OpSrai: alu_res = 32'($signed(ds_val) >>> shamt);
`ifdef EXEC_UNIT_P_MUL_EN
         OpMul:         alu_res = 32'($signed(ds_val) * $signed(dt_val));
`endif
         default:       alu_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alu_addr_q <= '0;
         alu_val_q  <= '0;
      end else begin
         alu_addr_q <= alu_hit ? dd : 6'd0;
         if (alu_hit && (dd != 6'd0)) alu_val_q <= alu_res;
      end
   end

   assign alu_addr   = alu_addr_q;
   assign alu_dd_val = alu_val_q;

   // Memory pipeline: stage k of ld_pipe_q carries the load's dd k cycles after d_addr is driven
   logic [DADDR_W-1:0]     mem_ea;
   logic [DADDR_W-1:0]     d_addr_q;
   logic [31:0]            d_wdata_q;
   logic                   d_we_q;
   logic [RAM_LAT:0][5:0]  ld_pipe_q;
   logic [31:0]            mem_val_q;
   logic                   mem_hit;

   assign mem_ea  = DADDR_W'(ds_val + sext_imm);
   assign mem_hit = (ld_pipe_q[RAM_LAT] != 6'd0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_we_q    <= 1'b0;
         ld_pipe_q <= '0;
         mem_val_q <= '0;
      end else begin
         if (is_mem) begin
            d_addr_q  <= mem_ea;
            d_wdata_q <= dt_val;
            d_we_q    <= ~ope[3];
         end else begin
            d_we_q    <= 1'b0;
         end
         ld_pipe_q[0] <= is_load ? dd : 6'd0;
         for (int unsigned i = 1; i <= RAM_LAT; i++) ld_pipe_q[i] <= ld_pipe_q[i-1];
         if (mem_hit) mem_val_q <= d_rdata;
      end
   end

   assign d_addr     = d_addr_q;
   assign d_wdata    = d_wdata_q;
   assign d_we       = d_we_q;
   assign d_en       = 1'b1;
   assign mem_addr   = ld_pipe_q[RAM_LAT];
   // Load data is forwarded straight from the RAM in its result cycle, then held
   assign mem_dd_val = mem_hit ? d_rdata : mem_val_q;

   // IO control FSM
   io_state_e state_q, state_d;
   logic      busy, in_pop, out_push;
   logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
   logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      in_pop   = 1'b0;
      out_push = 1'b0;
      case (state_q)
         StIdle: begin
            if (is_fence) begin
               busy    = 1'b1;
               state_d = StDrain;
            end else if (is_in) begin
               busy   = (in_cnt_q == '0);
               in_pop = (in_cnt_q != '0);
            end else if (is_out) begin
               busy     = (out_cnt_q == OUT_CW'(OUT_DEPTH));
               out_push = (out_cnt_q != OUT_CW'(OUT_DEPTH));
            end
         end
         StDrain: begin
            if (out_cnt_q != '0) busy = 1'b1;
            else                 state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   assign is_busy = {6'd0, busy};

   // Input byte FIFO
   logic [7:0]       in_mem_q [IN_DEPTH];
   logic [IN_AW-1:0] in_wr_q, in_rd_q;
   logic             in_rdy_q, in_push;
   logic [7:0]       in_head;

   assign in_push = io_in_vld & in_rdy_q;
   assign in_head = in_mem_q[in_rd_q];

   always_comb begin
      in_cnt_d = in_cnt_q;
      if (in_push && !in_pop)      in_cnt_d = in_cnt_q + IN_CW'(1);
      else if (!in_push && in_pop) in_cnt_d = in_cnt_q - IN_CW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_wr_q  <= '0;
         in_rd_q  <= '0;
         in_cnt_q <= '0;
         in_rdy_q <= 1'b0;
         for (int i = 0; i < int'(IN_DEPTH); i++) in_mem_q[i] <= '0;
      end else begin
         if (in_push) begin
            in_mem_q[in_wr_q] <= io_in_data;
            in_wr_q           <= in_wr_q + IN_AW'(1);
         end
         if (in_pop) in_rd_q <= in_rd_q + IN_AW'(1);
         in_cnt_q <= in_cnt_d;
         in_rdy_q <= (in_cnt_d != IN_CW'(IN_DEPTH));
      end
   end

   assign io_in_rdy = in_rdy_q;

   // Output byte FIFO
   logic [7:0]        out_mem_q [OUT_DEPTH];
   logic [OUT_AW-1:0] out_wr_q, out_rd_q;
   logic              out_pop;

   assign io_out_vld  = (out_cnt_q != '0);
   assign io_out_data = out_mem_q[out_rd_q];
   assign out_pop     = io_out_vld & io_out_rdy;

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (out_push && !out_pop)      out_cnt_d = out_cnt_q + OUT_CW'(1);
      else if (!out_push && out_pop) out_cnt_d = out_cnt_q - OUT_CW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_wr_q  <= '0;
         out_rd_q  <= '0;
         out_cnt_q <= '0;
         for (int i = 0; i < int'(OUT_DEPTH); i++) out_mem_q[i] <= '0;
      end else begin
         if (out_push) begin
            out_mem_q[out_wr_q] <= ds_val[7:0];
            out_wr_q            <= out_wr_q + OUT_AW'(1);
         end
         if (out_pop) out_rd_q <= out_rd_q + OUT_AW'(1);
         out_cnt_q <= out_cnt_d;
      end
   end

   // IN writeback
   logic [5:0]  io_addr_q;
   logic [31:0] io_val_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         io_addr_q <= '0;
         io_val_q  <= '0;
      end else if (in_pop) begin
         io_addr_q <= dd;
         if (dd != 6'd0) io_val_q <= {24'd0, in_head};
      end else begin
         io_addr_q <= '0;
      end
   end

   assign io_addr   = io_addr_q;
   assign io_dd_val = io_val_q;

endmodule

// File: tb/tb_exec_unit_p.sv
// Scoreboard bench for exec_unit_p: stimulus queues expected writebacks/stores/bytes,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_exec_unit_p;
   localparam int unsigned RAM_LAT   = 2;
   localparam int unsigned DADDR_W   = 17;
   localparam int unsigned IN_DEPTH  = 4;
   localparam int unsigned OUT_DEPTH = 4;

   localparam logic [5:0] NOP   = 6'b000000, ADD  = 6'b001100, ADDI = 6'b001000;
   localparam logic [5:0] SUB   = 6'b010100, SLL  = 6'b011100, SLLI = 6'b011000;
   localparam logic [5:0] SRL   = 6'b100100, SRLI = 6'b100000, SRA  = 6'b101100;
   localparam logic [5:0] SRAI  = 6'b101000, LUI  = 6'b110000, MUL  = 6'b110100;
   localparam logic [5:0] LOAD  = 6'b001111, STORE = 6'b000111;
   localparam logic [5:0] OP_IN = 6'b001011, OP_OUT = 6'b000011, FENCE = 6'b100011;

   logic               clk, rstn;
   logic [5:0]         ope, dd;
   logic [31:0]        ds_val, dt_val, d_rdata;
   logic [15:0]        imm;
   logic [6:0]         is_busy;
   logic [5:0]         alu_addr, mem_addr, io_addr;
   logic [31:0]        alu_dd_val, mem_dd_val, io_dd_val, d_wdata;
   logic [DADDR_W-1:0] d_addr;
   logic               d_en, d_we;
   logic [7:0]         io_in_data, io_out_data;
   logic               io_in_vld, io_in_rdy, io_out_vld, io_out_rdy;

   exec_unit_p #(
      .RAM_LAT(RAM_LAT), .DADDR_W(DADDR_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .ope(ope), .ds_val(ds_val), .dt_val(dt_val), .dd(dd),
      .imm(imm), .is_busy(is_busy), .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
      .mem_addr(mem_addr), .mem_dd_val(mem_dd_val), .io_addr(io_addr),
      .io_dd_val(io_dd_val), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_en(d_en), .d_we(d_we), .io_in_data(io_in_data), .io_in_vld(io_in_vld),
      .io_in_rdy(io_in_rdy), .io_out_data(io_out_data), .io_out_vld(io_out_vld),
      .io_out_rdy(io_out_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: read data appears RAM_LAT cycles after the address cycle
   logic [31:0] ram [256];
   logic [31:0] rd_pipe [RAM_LAT];
   initial for (int i = 0; i < 256; i++) ram[i] = 32'h0;
   always @(posedge clk) begin
      rd_pipe[0] <= ram[d_addr[7:0]];
      for (int i = 1; i < int'(RAM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
      if (d_we) ram[d_addr[7:0]] <= d_wdata;
   end
   assign d_rdata = rd_pipe[RAM_LAT-1];

   typedef struct { logic [5:0] addr; logic [31:0] val; int cyc; } wb_t;
   typedef struct { logic [DADDR_W-1:0] addr; logic [31:0] data; int cyc; } st_t;
   wb_t        alu_q[$], mem_q[$], io_q[$];
   st_t        st_q[$];
   logic [7:0] out_q[$];

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got 0x%0h, expected no event (cycle %0d)", name, act, cyc);
   endtask

   // Monitor
   wb_t        me;
   st_t        ms;
   logic [7:0] mb;
   always @(negedge clk) begin
      if (rstn) begin
         if (alu_addr != 6'd0) begin
            if (alu_q.size() == 0) unexpected("alu_unexpected", alu_addr);
            else begin
               me = alu_q.pop_front();
               check("alu_addr", alu_addr, me.addr);
               check("alu_val", alu_dd_val, me.val);
               check("alu_cycle", cyc, me.cyc);
            end
         end
         if (mem_addr != 6'd0) begin
            if (mem_q.size() == 0) unexpected("mem_unexpected", mem_addr);
            else begin
               me = mem_q.pop_front();
               check("mem_addr", mem_addr, me.addr);
               check("mem_val", mem_dd_val, me.val);
               check("mem_cycle", cyc, me.cyc);
            end
         end
         if (io_addr != 6'd0) begin
            if (io_q.size() == 0) unexpected("io_unexpected", io_addr);
            else begin
               me = io_q.pop_front();
               check("io_addr", io_addr, me.addr);
               check("io_val", io_dd_val, me.val);
               check("io_cycle", cyc, me.cyc);
            end
         end
         if (d_we) begin
            if (st_q.size() == 0) unexpected("store_unexpected", d_addr);
            else begin
               ms = st_q.pop_front();
               check("store_addr", d_addr, ms.addr);
               check("store_data", d_wdata, ms.data);
               check("store_cycle", cyc, ms.cyc);
            end
         end
         if (io_out_vld && io_out_rdy) begin
            if (out_q.size() == 0) unexpected("out_unexpected", io_out_data);
            else begin
               mb = out_q.pop_front();
               check("out_byte", io_out_data, mb);
            end
         end
      end
   end

   // Present an op, wait (bounded) until it is consumed; c = consume cycle
   task automatic issue(input logic [5:0] op, input logic [31:0] ds, input logic [31:0] dt,
                        input logic [5:0] d, input logic [15:0] im, output int c);
      int n;
      ope = op; ds_val = ds; dt_val = dt; dd = d; imm = im;
      n = 0;
      @(negedge clk);
      while (is_busy[0] && n < 64) begin
         n++;
         @(negedge clk);
      end
      if (is_busy[0]) unexpected("issue_timeout", op);
      c = cyc;
      @(posedge clk);
      #1;
      ope = NOP; dd = 6'd0;
   endtask

   task automatic alu_case(input logic [5:0] op, input logic [31:0] ds, input logic [31:0] dt,
                           input logic [15:0] im, input logic [5:0] d, input logic [31:0] res,
                           input bit wb);
      int c;
      issue(op, ds, dt, d, im, c);
      if (wb) alu_q.push_back('{d, res, c + 1});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_in(input logic [7:0] b);
      int n;
      io_in_data = b; io_in_vld = 1'b1; n = 0;
      @(negedge clk);
      while (!io_in_rdy && n < 32) begin
         n++;
         @(negedge clk);
      end
      if (!io_in_rdy) unexpected("push_in_timeout", b);
      @(posedge clk);
      #1;
      io_in_vld = 1'b0;
   endtask

   initial begin
      int c, n;
      rstn = 1'b0; ope = NOP; ds_val = '0; dt_val = '0; dd = '0; imm = '0;
      io_in_data = '0; io_in_vld = 1'b0; io_out_rdy = 1'b0;
      #3;
      check("rst_busy", is_busy, 7'd0);
      check("rst_alu_addr", alu_addr, 0);
      check("rst_alu_val", alu_dd_val, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_io_addr", io_addr, 0);
      check("rst_d_we", d_we, 0);
      check("rst_d_addr", d_addr, 0);
      check("rst_in_rdy", io_in_rdy, 0);
      check("rst_out_vld", io_out_vld, 0);
      check("d_en", d_en, 1);
      idle(2);
      rstn = 1'b1;
      check("in_rdy_before_edge", io_in_rdy, 0);
      idle(1);
      check("in_rdy_after_release", io_in_rdy, 1);

      // ALU
      alu_case(ADD,  32'd7,        32'hFFFFFFFD, 16'h0,    6'd5,  32'd4,        1);
      alu_case(SRAI, 32'h80000000, 32'h0,        16'h4,    6'd6,  32'hF8000000, 1);
      alu_case(ADDI, 32'd100,      32'h0,        16'hFFFF, 6'd1,  32'd99,       1);
      alu_case(SUB,  32'd5,        32'd8,        16'h0,    6'd2,  32'hFFFFFFFD, 1);
      alu_case(SLLI, 32'd3,        32'h0,        16'h4,    6'd3,  32'h30,       1);
      alu_case(SLL,  32'd1,        32'd31,       16'h0,    6'd4,  32'h80000000, 1);
      alu_case(SRL,  32'h80000000, 32'h21,       16'h0,    6'd7,  32'h40000000, 1);
      alu_case(SRLI, 32'hF0,       32'h0,        16'h4,    6'd8,  32'hF,        1);
      alu_case(SRA,  32'hFFFFFF00, 32'd4,        16'h0,    6'd9,  32'hFFFFFFF0, 1);
      alu_case(LUI,  32'hAAAA5678, 32'h0,        16'h1234, 6'd10, 32'h12345678, 1);
      alu_case(ADD,  32'd1,        32'd2,        16'h0,    6'd0,  32'd3,        0);
      check("alu_val_held", alu_dd_val, 32'h12345678);
      alu_case(6'b010000, 32'd1,   32'd2,        16'h0,    6'd11, 32'd0,        0);
`ifdef EXEC_UNIT_P_MUL_EN
      alu_case(MUL,  32'd6,        32'hFFFFFFFD, 16'h0,    6'd12, 32'hFFFFFFEE, 1);
`else
      alu_case(MUL,  32'd6,        32'hFFFFFFFD, 16'h0,    6'd12, 32'd0,        0);
`endif
      idle(3);

      // Memory
      issue(STORE, 32'h10, 32'hDEADBEEF, 6'd0, 16'hFFFC, c);
      st_q.push_back('{17'h0000C, 32'hDEADBEEF, c + 1});
      issue(LOAD, 32'h10, 32'h0, 6'd9, 16'hFFFC, c);
      mem_q.push_back('{6'd9, 32'hDEADBEEF, c + 1 + RAM_LAT});
      issue(STORE, 32'h0001FFFF, 32'hCAFEF00D, 6'd0, 16'h0002, c);
      st_q.push_back('{17'h00001, 32'hCAFEF00D, c + 1});
      issue(LOAD, 32'h00020001, 32'h0, 6'd10, 16'h0, c);
      mem_q.push_back('{6'd10, 32'hCAFEF00D, c + 1 + RAM_LAT});
      issue(LOAD, 32'h0, 32'h0, 6'd11, 16'h000C, c);
      mem_q.push_back('{6'd11, 32'hDEADBEEF, c + 1 + RAM_LAT});
      issue(LOAD, 32'h0, 32'h0, 6'd0, 16'h000C, c);
      idle(6);
      check("mem_val_held", mem_dd_val, 32'hDEADBEEF);

      // IN on empty FIFO, byte arrives later
      ope = OP_IN; dd = 6'd12;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("in_empty_busy", is_busy[0], 1);
         @(posedge clk);
         #1;
      end
      io_in_data = 8'h41; io_in_vld = 1'b1;
      @(negedge clk);
      check("in_push_same_cycle_busy", is_busy[0], 1);
      @(posedge clk);
      #1;
      io_in_vld = 1'b0;
      @(negedge clk);
      check("in_consume", is_busy[0], 0);
      io_q.push_back('{6'd12, 32'h41, cyc + 1});
      @(posedge clk);
      #1;
      ope = NOP; dd = 6'd0;
      idle(2);

      // IN with dd=0 pops without writeback
      push_in(8'h55);
      push_in(8'h66);
      issue(OP_IN, 32'h0, 32'h0, 6'd0, 16'h0, c);
      check("io_val_held", io_dd_val, 32'h41);
      issue(OP_IN, 32'h0, 32'h0, 6'd13, 16'h0, c);
      io_q.push_back('{6'd13, 32'h66, c + 1});
      idle(2);

      // Fill input FIFO, extra byte dropped while full
      for (int i = 0; i < 4; i++) push_in(8'hA1 + 8'(i));
      @(negedge clk);
      check("in_full_rdy", io_in_rdy, 0);
      io_in_data = 8'hEE; io_in_vld = 1'b1;
      idle(2);
      io_in_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(OP_IN, 32'h0, 32'h0, 6'(14 + i), 16'h0, c);
         io_q.push_back('{6'(14 + i), 32'hA1 + 32'(i), c + 1});
      end
      idle(2);
      check("in_empty_after_drain_rdy", io_in_rdy, 1);

      // OUT FIFO fill and stall
      io_out_rdy = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         issue(OP_OUT, 32'(i), 32'h0, 6'd0, 16'h0, c);
         out_q.push_back(8'(i));
      end
      ope = OP_OUT; ds_val = 32'h05;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("out_full_busy", is_busy[0], 1);
         @(posedge clk);
         #1;
      end
      io_out_rdy = 1'b1;
      @(negedge clk);
      check("out_full_rdy_same_cycle_busy", is_busy[0], 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("out_after_pop_busy", is_busy[0], 0);
      out_q.push_back(8'h05);
      @(posedge clk);
      #1;
      ope = NOP;
      idle(8);

      // FENCE waits for the output FIFO to drain
      io_out_rdy = 1'b0;
      issue(OP_OUT, 32'h77, 32'h0, 6'd0, 16'h0, c);
      out_q.push_back(8'h77);
      issue(OP_OUT, 32'h88, 32'h0, 6'd0, 16'h0, c);
      out_q.push_back(8'h88);
      ope = FENCE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fence_busy", is_busy[0], 1);
         @(posedge clk);
         #1;
      end
      io_out_rdy = 1'b1;
      n = 0;
      @(negedge clk);
      while (is_busy[0] && n < 32) begin
         n++;
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      check("fence_drain_cycles", n, 2);
      check("fence_out_empty", io_out_vld, 0);
      @(posedge clk);
      #1;
      ope = NOP;
      issue(OP_OUT, 32'h5A, 32'h0, 6'd0, 16'h0, c);
      out_q.push_back(8'h5A);
      idle(4);

      // Reset mid-load with bytes queued
      io_out_rdy = 1'b0;
      alu_case(ADD, 32'd1, 32'd1, 16'h0, 6'd3, 32'd2, 1);
      issue(OP_OUT, 32'h99, 32'h0, 6'd0, 16'h0, c);
      issue(OP_OUT, 32'h9A, 32'h0, 6'd0, 16'h0, c);
      issue(LOAD, 32'h0, 32'h0, 6'd20, 16'h000C, c);
      rstn = 1'b0;
      #1;
      check("mid_rst_mem_addr", mem_addr, 0);
      check("mid_rst_mem_val", mem_dd_val, 0);
      check("mid_rst_alu_val", alu_dd_val, 0);
      check("mid_rst_io_val", io_dd_val, 0);
      check("mid_rst_d_addr", d_addr, 0);
      check("mid_rst_d_wdata", d_wdata, 0);
      check("mid_rst_out_vld", io_out_vld, 0);
      check("mid_rst_out_data", io_out_data, 0);
      check("mid_rst_in_rdy", io_in_rdy, 0);
      alu_q.delete(); mem_q.delete(); io_q.delete(); st_q.delete(); out_q.delete();
      idle(2);
      rstn = 1'b1;
      io_out_rdy = 1'b1;
      for (int i = 0; i < int'(RAM_LAT) + 3; i++) begin
         @(negedge clk);
         check("post_rst_mem_addr", mem_addr, 0);
         check("post_rst_out_vld", io_out_vld, 0);
      end
      idle(2);

      check("alu_pending", alu_q.size(), 0);
      check("mem_pending", mem_q.size(), 0);
      check("io_pending", io_q.size(), 0);
      check("store_pending", st_q.size(), 0);
      check("out_pending", out_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
